// File: rtl/sobel_frame_sequencer_if.sv
// Handshake bundle between the Sobel frame sequencer and its camera, engine and display peers.
// The sequencer sits on the slave side; the system side drives the master modport.
interface sobel_frame_sequencer_if #(
   parameter int CNT_W = 8
);
   logic             enable;
   logic             frame_captured;
   logic             vsync_pulse;
   logic             sobel_done;
   logic             sobel_start;
   logic             capture_sel;
   logic             sobel_sel;
   logic             edge_valid;
   logic             busy;
   logic             timeout_err;
   logic [CNT_W-1:0] frame_count;
   logic [CNT_W-1:0] dropped_count;

   modport master (
      output enable, frame_captured, vsync_pulse, sobel_done,
      input  sobel_start, capture_sel, sobel_sel, edge_valid, busy,
             timeout_err, frame_count, dropped_count
   );

   modport slave (
      input  enable, frame_captured, vsync_pulse, sobel_done,
      output sobel_start, capture_sel, sobel_sel, edge_valid, busy,
             timeout_err, frame_count, dropped_count
   );
endinterface

// File: rtl/sobel_frame_sequencer.sv
// Swaps the double-buffered picture memory per captured frame, runs the Sobel engine,
// publishes the edge map on vsync, and watches for a hung engine and dropped frames.
module sobel_frame_sequencer #(
   parameter int TIMEOUT_CYCLES = 8_000_000,
   parameter int CNT_W          = 8
) (
   input logic                     clk,
   input logic                     reset,
   sobel_frame_sequencer_if.slave  seq
);
   localparam int RUN_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_FRAME,
      ARM,
      RUN,
      PUBLISH
   } state_t;

   state_t           state, state_next;
   logic             arm_cnt;
   logic [RUN_W-1:0] run_cnt;
   logic             swap, publish, timeout_hit, drop;

   logic             sobel_start, capture_sel, sobel_sel, edge_valid, busy, timeout_err;
   logic [CNT_W-1:0] frame_count, dropped_count;

   // NOTE: every output of this block gets a default first so no path leaves a latch behind.
   always_comb begin
      state_next  = state;
      swap        = 1'b0;
      publish     = 1'b0;
      timeout_hit = 1'b0;
      case (state)
         IDLE:       if (seq.enable) state_next = WAIT_FRAME;
         WAIT_FRAME: if (seq.frame_captured) begin
                        state_next = ARM;
                        swap       = 1'b1;
                     end
         ARM:        if (arm_cnt) state_next = RUN;
         RUN:        if (seq.sobel_done) begin
                        state_next = PUBLISH;
                     end else if (run_cnt == RUN_LAST) begin
                        state_next  = WAIT_FRAME;
                        timeout_hit = 1'b1;
                     end
         PUBLISH:    if (seq.vsync_pulse) begin
                        state_next = WAIT_FRAME;
                        publish    = 1'b1;
                     end
         default:    state_next = IDLE;
      endcase
      if (!seq.enable) begin
         state_next  = IDLE;
         swap        = 1'b0;
         publish     = 1'b0;
         timeout_hit = 1'b0;
      end
   end

   // The camera keeps overwriting its own buffer whenever the engine side is occupied.
   assign drop = seq.frame_captured && (state inside {ARM, RUN, PUBLISH});

   // NOTE: all sequential state uses non-blocking assignments so every flop sees pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         arm_cnt       <= 1'b0;
         run_cnt       <= '0;
         sobel_start   <= 1'b0;
         capture_sel   <= 1'b0;
         sobel_sel     <= 1'b1;
         edge_valid    <= 1'b0;
         busy          <= 1'b0;
         timeout_err   <= 1'b0;
         frame_count   <= '0;
         dropped_count <= '0;
      end else begin
         state       <= state_next;
         arm_cnt     <= (state == ARM) ? ~arm_cnt : 1'b0;
         run_cnt     <= (state == RUN) ? run_cnt + 1'b1 : '0;
         sobel_start <= state_next inside {RUN, PUBLISH};
         busy        <= state_next inside {ARM, RUN, PUBLISH};
         if (swap) begin
            capture_sel <= ~capture_sel;
            sobel_sel   <= capture_sel;
         end
         if (swap || !seq.enable) edge_valid <= 1'b0;
         else if (publish)        edge_valid <= 1'b1;
         if (timeout_hit) timeout_err <= 1'b1;
         if (publish)     frame_count <= frame_count + 1'b1;
         if (drop && (dropped_count != '1)) dropped_count <= dropped_count + 1'b1;
      end
   end

   assign seq.sobel_start   = sobel_start;
   assign seq.capture_sel   = capture_sel;
   assign seq.sobel_sel     = sobel_sel;
   assign seq.edge_valid    = edge_valid;
   assign seq.busy          = busy;
   assign seq.timeout_err   = timeout_err;
   assign seq.frame_count   = frame_count;
   assign seq.dropped_count = dropped_count;
endmodule

// File: tb/tb_sobel_frame_sequencer.sv
// Directed bench for sobel_frame_sequencer with hand-computed expectations.
// Inputs change 1 ns after a rising edge; outputs are read at that same point.
module tb_sobel_frame_sequencer;
   logic clk = 1'b0;
   logic reset;
   int   tests_run    = 0;
   int   tests_failed = 0;
   int   run_cycles;

   sobel_frame_sequencer_if #(.CNT_W(8)) bus ();

   sobel_frame_sequencer #(
      .TIMEOUT_CYCLES(100),
      .CNT_W         (8)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .seq  (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One-cycle capture pulse; returns at N+1 relative to the sampling edge N.
   task automatic capture();
      bus.frame_captured = 1'b1;
      step();
      bus.frame_captured = 1'b0;
   endtask

   task automatic done_pulse();
      bus.sobel_done = 1'b1;
      step();
      bus.sobel_done = 1'b0;
   endtask

   task automatic vsync();
      bus.vsync_pulse = 1'b1;
      step();
      bus.vsync_pulse = 1'b0;
   endtask

   initial begin
      reset              = 1'b1;
      bus.enable         = 1'b0;
      bus.frame_captured = 1'b0;
      bus.vsync_pulse    = 1'b0;
      bus.sobel_done     = 1'b0;
      repeat (3) step();

      check("rst_start",   int'(bus.sobel_start),   0);
      check("rst_cap_sel", int'(bus.capture_sel),   0);
      check("rst_sob_sel", int'(bus.sobel_sel),     1);
      check("rst_valid",   int'(bus.edge_valid),    0);
      check("rst_busy",    int'(bus.busy),          0);
      check("rst_tmo",     int'(bus.timeout_err),   0);
      check("rst_fc",      int'(bus.frame_count),   0);
      check("rst_drop",    int'(bus.dropped_count), 0);

      reset = 1'b0;
      step();
      capture();
      step();
      check("idle_cap_sel",  int'(bus.capture_sel),   0);
      check("idle_cap_drop", int'(bus.dropped_count), 0);
      check("idle_cap_busy", int'(bus.busy),          0);

      // Normal frame: capture, two ARM cycles, 50-cycle engine run, vsync later.
      bus.enable = 1'b1;
      repeat (2) step();
      capture();
      check("n1_cap_sel",  int'(bus.capture_sel), 1);
      check("n1_sob_sel",  int'(bus.sobel_sel),   0);
      check("n1_busy",     int'(bus.busy),        1);
      check("n1_start_a1", int'(bus.sobel_start), 0);
      step();
      check("n2_start_a2", int'(bus.sobel_start), 0);
      step();
      check("n3_start_run", int'(bus.sobel_start), 1);
      repeat (49) step();
      check("run_start", int'(bus.sobel_start), 1);
      check("run_valid", int'(bus.edge_valid),  0);
      done_pulse();
      check("pub_start", int'(bus.sobel_start), 1);
      check("pub_busy",  int'(bus.busy),        1);
      repeat (5) step();
      vsync();
      check("pub_valid", int'(bus.edge_valid),  1);
      check("pub_fc",    int'(bus.frame_count), 1);
      check("pub_start_off", int'(bus.sobel_start), 0);
      check("pub_busy_off",  int'(bus.busy),        0);

      // Hung engine: exactly 100 RUN cycles, then abort.
      capture();
      check("tmo_cap_sel", int'(bus.capture_sel), 0);
      repeat (2) step();
      run_cycles = 0;
      while (bus.sobel_start && run_cycles < 200) begin
         run_cycles++;
         step();
      end
      check("tmo_run_cycles", run_cycles, 100);
      check("tmo_err",   int'(bus.timeout_err), 1);
      check("tmo_busy",  int'(bus.busy),        0);
      check("tmo_valid", int'(bus.edge_valid),  0);
      capture();
      check("tmo_recap_sel", int'(bus.capture_sel), 1);
      repeat (12) step();
      done_pulse();
      vsync();
      check("tmo_good_valid", int'(bus.edge_valid),  1);
      check("tmo_good_fc",    int'(bus.frame_count), 2);
      check("tmo_err_sticky", int'(bus.timeout_err), 1);

      // Drops during RUN, plus one on the cycle PUBLISH exits.
      capture();
      check("drp_cap_sel", int'(bus.capture_sel), 0);
      repeat (2) step();
      for (int i = 0; i < 3; i++) begin
         capture();
         step();
      end
      check("drp_run3", int'(bus.dropped_count), 3);
      check("drp_sel",  int'(bus.capture_sel),   0);
      done_pulse();
      bus.frame_captured = 1'b1;
      vsync();
      bus.frame_captured = 1'b0;
      check("drp_exit", int'(bus.dropped_count), 4);
      check("drp_fc",   int'(bus.frame_count),   3);
      check("drp_exit_sel", int'(bus.capture_sel), 0);

      // done and vsync together in RUN: vsync is not consumed.
      capture();
      check("dv_cap_sel", int'(bus.capture_sel), 1);
      repeat (2) step();
      bus.sobel_done  = 1'b1;
      bus.vsync_pulse = 1'b1;
      step();
      bus.sobel_done  = 1'b0;
      bus.vsync_pulse = 1'b0;
      check("dv_valid0", int'(bus.edge_valid),  0);
      check("dv_start",  int'(bus.sobel_start), 1);
      repeat (3) step();
      check("dv_valid_hold", int'(bus.edge_valid), 0);
      vsync();
      check("dv_valid1", int'(bus.edge_valid),  1);
      check("dv_fc",     int'(bus.frame_count), 4);

      // enable dropped mid-RUN, then resume.
      capture();
      check("en_cap_sel", int'(bus.capture_sel), 0);
      repeat (7) step();
      bus.enable = 1'b0;
      step();
      check("en_off_start", int'(bus.sobel_start), 0);
      check("en_off_valid", int'(bus.edge_valid),  0);
      check("en_off_busy",  int'(bus.busy),        0);
      check("en_off_csel",  int'(bus.capture_sel), 0);
      check("en_off_ssel",  int'(bus.sobel_sel),   1);
      check("en_off_fc",    int'(bus.frame_count), 4);
      step();
      bus.enable = 1'b1;
      step();
      capture();
      check("en_re_csel", int'(bus.capture_sel), 1);
      check("en_re_busy", int'(bus.busy),        1);
      repeat (2) step();
      check("en_re_start", int'(bus.sobel_start), 1);

      // Saturate the drop counter while parked in PUBLISH, then reset with vsync.
      done_pulse();
      bus.frame_captured = 1'b1;
      repeat (300) step();
      bus.frame_captured = 1'b0;
      check("sat_drop",  int'(bus.dropped_count), 255);
      check("sat_start", int'(bus.sobel_start),   1);
      bus.vsync_pulse = 1'b1;
      reset           = 1'b1;
      step();
      bus.vsync_pulse = 1'b0;
      check("rv_fc",    int'(bus.frame_count),   0);
      check("rv_valid", int'(bus.edge_valid),    0);
      check("rv_start", int'(bus.sobel_start),   0);
      check("rv_csel",  int'(bus.capture_sel),   0);
      check("rv_ssel",  int'(bus.sobel_sel),     1);
      check("rv_busy",  int'(bus.busy),          0);
      check("rv_tmo",   int'(bus.timeout_err),   0);
      check("rv_drop",  int'(bus.dropped_count), 0);
      reset = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule

// File: doc/sobel_frame_sequencer.md
# sobel_frame_sequencer

Sequences the Sobel edge engine across a double-buffered picture memory. The camera writer fills one picture buffer while the Sobel engine reads the other. This block swaps buffers on each captured frame, runs the engine with its level-sensitive start/done protocol, and publishes the finished edge map to the display on a vsync boundary. It also watches for a hung engine and counts frames that are dropped while the engine is busy.

## Interface

Parameters:
- TIMEOUT_CYCLES, 8_000_000, maximum cycles in RUN before abort; a full 640x480 pass completes well inside this.
- CNT_W, 8, width of frame_count and dropped_count.

Ports:
- clk  in  1  system clock; everything is synchronous to it.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  level; 0 forces IDLE.
- frame_captured  in  1  one-cycle pulse from the camera writer when its buffer holds a complete frame.
- vsync_pulse  in  1  one-cycle pulse at display start of frame.
- sobel_done  in  1  engine done flag; only meaningful while sobel_start=1.
- sobel_start  out  1  engine start level; 0 resets the engine, 1 runs it.
- capture_sel  out  1  picture buffer the camera writes.
- sobel_sel  out  1  picture buffer the engine reads; always equals ~capture_sel.
- edge_valid  out  1  edge memory holds a complete, published result.
- busy  out  1  high in ARM, RUN and PUBLISH.
- timeout_err  out  1  sticky; set on RUN timeout and cleared only by reset.
- frame_count  out  CNT_W  published frames; wraps.
- dropped_count  out  CNT_W  captures ignored while busy; saturates at all-ones.

## Operation

Reset values:
- sobel_start=0, capture_sel=0, sobel_sel=1.
- edge_valid=0, busy=0, timeout_err=0, frame_count=0, dropped_count=0.
- State IDLE; run counter 0.

States:
- IDLE: sobel_start=0. Goes to WAIT_FRAME when enable=1. A frame_captured pulse in IDLE is ignored and not counted.
- WAIT_FRAME: sobel_start=0. On frame_captured, toggle capture_sel and sobel_sel together, then go to ARM.
- ARM: sobel_start=0 for exactly 2 cycles, which guarantees the engine re-initialises. edge_valid is cleared on entry because the edge memory is about to be overwritten. Then go to RUN with the run counter cleared.
- RUN: sobel_start=1 and the run counter increments.
  - sobel_done=1 goes to PUBLISH.
  - Otherwise, when the counter reaches TIMEOUT_CYCLES-1, set timeout_err, drop sobel_start and go to WAIT_FRAME. edge_valid stays 0.
- PUBLISH: sobel_start is held 1 so the engine's done flag stays latched. On vsync_pulse: set edge_valid=1, increment frame_count, drop sobel_start and go to WAIT_FRAME.

Boundary rules:
- frame_captured in ARM, RUN or PUBLISH: buffers are not swapped (the camera overwrites its own buffer) and dropped_count increments unless already saturated.
- frame_captured on the same cycle PUBLISH exits: counted as dropped.
- sobel_done and vsync_pulse in the same RUN cycle: the vsync is not consumed, so the block waits for the next vsync.
- sobel_done seen in any state other than RUN: ignored.
- enable=0 in any state: next state IDLE, sobel_start=0 and edge_valid=0. Buffer selects, counters and timeout_err are retained.
- reset has priority over everything, including enable and in-flight pulses.

## Timing

- All outputs are registered.
- frame_captured sampled in WAIT_FRAME at cycle N:
  - selects toggled at N+1;
  - ARM occupies N+1 and N+2;
  - sobel_start=1 from N+3.
- sobel_done sampled high at cycle M in RUN: state is PUBLISH at M+1.
- vsync_pulse sampled at cycle V in PUBLISH: edge_valid=1, frame_count+1 and sobel_start=0 at V+1.
- Timeout: sobel_start=0 and timeout_err=1 on the cycle after the TIMEOUT_CYCLES-th RUN cycle.
- Minimum capture-to-publish latency: 4 cycles plus engine runtime plus the wait for vsync.

## Test plan

- Reset, enable=1, frame_captured at cycle 10, engine model raises done 50 cycles after start, vsync at cycle 80 -> capture_sel=1 and sobel_sel=0 at cycle 11; sobel_start=1 from cycle 13; edge_valid=1 and frame_count=1 at cycle 81; sobel_start=0 at cycle 81.
- TIMEOUT_CYCLES=100, engine never raises done -> exactly 100 RUN cycles, then sobel_start=0, timeout_err=1, state WAIT_FRAME; a subsequent good frame still publishes while timeout_err stays 1.
- Three frame_captured pulses during RUN -> dropped_count=3 and capture_sel unchanged; 300 drops with CNT_W=8 -> dropped_count=255.
- done and vsync in the same cycle -> edge_valid stays 0 until the next vsync, then becomes 1 one cycle after it.
- enable dropped mid-RUN -> next cycle IDLE, sobel_start=0, edge_valid=0, selects unchanged; re-enable followed by a capture -> normal sequence resumes with selects toggled.
- reset asserted in PUBLISH together with vsync -> every output returns to its reset value one cycle later, and frame_count is not incremented.
